// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-outstanding round-robin arbiter sharing one memory port
//               between icache line fills and dcache fills/write-backs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int CACHE_LINE_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        ic_req_valid,
    input  logic [ADDRESS_WIDTH-1:0]    ic_req_addr,
    output logic                        ic_req_ready,
    output logic                        ic_resp_valid,
    output logic [CACHE_LINE_WIDTH-1:0] ic_resp_data,

    input  logic                        dc_req_valid,
    input  logic                        dc_req_write,
    input  logic [ADDRESS_WIDTH-1:0]    dc_req_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] dc_req_data,
    output logic                        dc_req_ready,
    output logic                        dc_resp_valid,
    output logic [CACHE_LINE_WIDTH-1:0] dc_resp_data,

    output logic                        mem_req_valid,
    output logic                        mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]    mem_req_addr,
    output logic [CACHE_LINE_WIDTH-1:0] mem_req_data,
    input  logic                        mem_resp_valid,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam logic c_own_ic = 1'b0;
    localparam logic c_own_dc = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_owner;
    logic       r_last_grant;

    logic w_idle;
    logic w_grant_ic;
    logic w_grant_dc;
    logic w_accept;
    logic w_resp_capture;

    // On conflict the requester that did not win last time goes first.
    assign w_idle       = (r_state == c_st_idle) && !reset;
    assign w_grant_dc   = dc_req_valid && (!ic_req_valid || (r_last_grant == c_own_ic));
    assign w_grant_ic   = ic_req_valid && !w_grant_dc;
    assign ic_req_ready = w_idle && w_grant_ic;
    assign dc_req_ready = w_idle && w_grant_dc;
    assign w_accept     = ic_req_ready || dc_req_ready;

    assign w_resp_capture = (r_state == c_st_wait) && mem_resp_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_accept)       w_next_state = c_st_issue;
            c_st_issue:                     w_next_state = c_st_wait;
            c_st_wait:  if (mem_resp_valid) w_next_state = c_st_resp;
            c_st_resp:                      w_next_state = c_st_idle;
            default:                        w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= c_own_ic;
            r_last_grant  <= c_own_ic;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
        end else begin
            mem_req_valid <= 1'b0;
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;

            // Icache requests are always reads, so write/data are forced low.
            if (w_accept) begin
                r_owner       <= dc_req_ready ? c_own_dc : c_own_ic;
                r_last_grant  <= dc_req_ready ? c_own_dc : c_own_ic;
                mem_req_valid <= 1'b1;
                mem_req_write <= dc_req_ready && dc_req_write;
                mem_req_addr  <= dc_req_ready ? dc_req_addr : ic_req_addr;
                mem_req_data  <= dc_req_ready ? dc_req_data : '0;
            end

            // Registering the response here makes resp_valid land in the RESP cycle.
            if (w_resp_capture) begin
                if (r_owner == c_own_dc) begin
                    dc_resp_valid <= 1'b1;
                    dc_resp_data  <= mem_req_write ? '0 : mem_resp_data;
                end else begin
                    ic_resp_valid <= 1'b1;
                    ic_resp_data  <= mem_req_write ? '0 : mem_resp_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    localparam logic [LW-1:0] c_line_ic  = 128'hDEADBEEF_00000000_11111111_CAFEF00D;
    localparam logic [LW-1:0] c_line_a5  = {16{8'hA5}};
    localparam logic [LW-1:0] c_line_wr  = 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0;
    localparam logic [LW-1:0] c_line_1   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [LW-1:0] c_line_2   = 128'h55555555_66666666_77777777_88888888;
    localparam logic [LW-1:0] c_line_3   = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    localparam logic [LW-1:0] c_line_4   = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;
    localparam logic [LW-1:0] c_line_5   = 128'hFEEDFACE_01234567_89ABCDEF_76543210;
    localparam logic [LW-1:0] c_line_7   = 128'h00000007_00000007_00000007_00000007;
    localparam logic [LW-1:0] c_line_8   = 128'h88880000_00008888_88880000_00008888;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid;
    logic [AW-1:0] ic_req_addr;
    logic          ic_req_ready;
    logic          ic_resp_valid;
    logic [LW-1:0] ic_resp_data;
    logic          dc_req_valid;
    logic          dc_req_write;
    logic [AW-1:0] dc_req_addr;
    logic [LW-1:0] dc_req_data;
    logic          dc_req_ready;
    logic          dc_resp_valid;
    logic [LW-1:0] dc_resp_data;
    logic          mem_req_valid;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_data;
    logic          mem_resp_valid;
    logic [LW-1:0] mem_resp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDRESS_WIDTH    (AW),
        .CACHE_LINE_WIDTH (LW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_data   (ic_resp_data),
        .dc_req_valid   (dc_req_valid),
        .dc_req_write   (dc_req_write),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_ready   (dc_req_ready),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_data   (dc_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    // One cycle boundary: inputs are changed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_0040;
        dc_req_valid = 1'b1;
        dc_req_write = 1'b0;
        dc_req_addr  = 32'h0000_0080;
        dc_req_data  = '0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) step();
        #1;
        checks++;
        if ({ic_req_ready, dc_req_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready actual=%b required=00", {ic_req_ready, dc_req_ready});
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        reset        = 1'b0;
        step();
        checks++;
        if ({mem_req_valid, mem_req_write, ic_resp_valid, dc_resp_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=0000",
                     {mem_req_valid, mem_req_write, ic_resp_valid, dc_resp_valid});
        end
        checks++;
        if ({mem_req_addr, mem_req_data, ic_resp_data, dc_resp_data} !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%h data=%h ic=%h dc=%h required=0",
                     mem_req_addr, mem_req_data, ic_resp_data, dc_resp_data);
        end
    endtask

    task automatic test_ic_read();
        logic bad;
        bad = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1000;
        #1;
        checks++;
        if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
            failures++;
            $display("FAIL ic_read_ready actual=%b required=10", {ic_req_ready, dc_req_ready});
        end
        step();
        ic_req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            failures++;
            $display("FAIL ic_read_issue valid=%b write=%b addr=%h required=1/0/00001000",
                     mem_req_valid, mem_req_write, mem_req_addr);
        end
        for (int c = 2; c <= 11; c++) begin
            step();
            if (ic_resp_valid || dc_resp_valid || mem_req_valid) bad = 1'b1;
            if (c == 11) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = c_line_ic;
            end
        end
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({ic_resp_valid, dc_resp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL ic_read_resp_valid actual=%b required=10", {ic_resp_valid, dc_resp_valid});
        end
        checks++;
        if (ic_resp_data !== c_line_ic) begin
            failures++;
            $display("FAIL ic_read_resp_data actual=%h required=%h", ic_resp_data, c_line_ic);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL ic_read_quiet_wait actual=%b required=0", bad);
        end
        step();
        checks++;
        if (ic_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ic_read_pulse actual=%b required=0", ic_resp_valid);
        end
    endtask

    task automatic test_dc_write();
        dc_req_valid = 1'b1;
        dc_req_write = 1'b1;
        dc_req_addr  = 32'h0000_2040;
        dc_req_data  = c_line_a5;
        #1;
        checks++;
        if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL dc_write_ready actual=%b required=01", {ic_req_ready, dc_req_ready});
        end
        step();
        dc_req_valid = 1'b0;
        dc_req_write = 1'b0;
        dc_req_data  = '0;
        checks++;
        if ({mem_req_valid, mem_req_write, mem_req_addr} !== {1'b1, 1'b1, 32'h0000_2040}) begin
            failures++;
            $display("FAIL dc_write_issue valid=%b write=%b addr=%h required=1/1/00002040",
                     mem_req_valid, mem_req_write, mem_req_addr);
        end
        checks++;
        if (mem_req_data !== c_line_a5) begin
            failures++;
            $display("FAIL dc_write_data actual=%h required=%h", mem_req_data, c_line_a5);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_wr;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({ic_resp_valid, dc_resp_valid, dc_resp_data} !== {2'b01, {LW{1'b0}}}) begin
            failures++;
            $display("FAIL dc_write_ack valid=%b%b data=%h required=01/0",
                     ic_resp_valid, dc_resp_valid, dc_resp_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic bad;
        bad   = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_3000;
        dc_req_valid = 1'b1;
        dc_req_write = 1'b0;
        dc_req_addr  = 32'h0000_4000;
        #1;
        checks++;
        if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_first_grant actual=%b required=01", {ic_req_ready, dc_req_ready});
        end
        step();
        dc_req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_4000}) begin
            failures++;
            $display("FAIL b2b_dc_issue valid=%b addr=%h required=1/00004000", mem_req_valid, mem_req_addr);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_1;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({dc_resp_valid, dc_resp_data, ic_req_ready} !== {1'b1, c_line_1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_dc_resp valid=%b data=%h ic_ready=%b required=1/%h/0",
                     dc_resp_valid, dc_resp_data, ic_req_ready, c_line_1);
        end
        step();
        checks++;
        if (ic_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ic_grant actual=%b required=1", ic_req_ready);
        end
        step();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b1;
        dc_req_addr  = 32'h0000_5000;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_3000}) begin
            failures++;
            $display("FAIL b2b_ic_issue valid=%b addr=%h required=1/00003000", mem_req_valid, mem_req_addr);
        end
        if (dc_req_ready) bad = 1'b1;
        step();
        if (dc_req_ready) bad = 1'b1;
        step();
        if (dc_req_ready) bad = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_2;
        step();
        mem_resp_valid = 1'b0;
        if (dc_req_ready) bad = 1'b1;
        checks++;
        if ({ic_resp_valid, ic_resp_data, dc_resp_valid} !== {1'b1, c_line_2, 1'b0}) begin
            failures++;
            $display("FAIL b2b_ic_resp valid=%b data=%h dc_valid=%b required=1/%h/0",
                     ic_resp_valid, ic_resp_data, dc_resp_valid, c_line_2);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dc_held actual=%b required=0", bad);
        end
        step();
        checks++;
        if (dc_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_third_grant actual=%b required=1", dc_req_ready);
        end
        step();
        dc_req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_5000}) begin
            failures++;
            $display("FAIL b2b_third_issue valid=%b addr=%h required=1/00005000", mem_req_valid, mem_req_addr);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_3;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({dc_resp_valid, dc_resp_data} !== {1'b1, c_line_3}) begin
            failures++;
            $display("FAIL b2b_third_resp valid=%b data=%h required=1/%h", dc_resp_valid, dc_resp_data, c_line_3);
        end
        step();
    endtask

    task automatic test_held_request();
        logic bad;
        bad = 1'b0;
        dc_req_valid = 1'b1;
        dc_req_write = 1'b0;
        dc_req_addr  = 32'h0000_7000;
        step();
        dc_req_valid = 1'b0;
        step();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_6000;
        #1;
        if (ic_req_ready) bad = 1'b1;
        step();
        ic_req_addr = 32'h0000_6040;
        #1;
        if (ic_req_ready) bad = 1'b1;
        step();
        if (ic_req_ready) bad = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_4;
        step();
        mem_resp_valid = 1'b0;
        if (ic_req_ready) bad = 1'b1;
        checks++;
        if ({dc_resp_valid, dc_resp_data} !== {1'b1, c_line_4}) begin
            failures++;
            $display("FAIL held_dc_resp valid=%b data=%h required=1/%h", dc_resp_valid, dc_resp_data, c_line_4);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL held_ready_low actual=%b required=0", bad);
        end
        step();
        checks++;
        if (ic_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL held_grant actual=%b required=1", ic_req_ready);
        end
        step();
        ic_req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_6040}) begin
            failures++;
            $display("FAIL held_addr valid=%b addr=%h required=1/00006040", mem_req_valid, mem_req_addr);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_5;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({ic_resp_valid, ic_resp_data} !== {1'b1, c_line_5}) begin
            failures++;
            $display("FAIL held_ic_resp valid=%b data=%h required=1/%h", ic_resp_valid, ic_resp_data, c_line_5);
        end
        step();
    endtask

    task automatic test_stray_resp();
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_8;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({ic_resp_valid, dc_resp_valid, mem_req_valid} !== 3'b000) begin
            failures++;
            $display("FAIL stray_no_resp actual=%b required=000", {ic_resp_valid, dc_resp_valid, mem_req_valid});
        end
        step();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_A000;
        #1;
        checks++;
        if ({ic_resp_valid, dc_resp_valid, ic_req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL stray_still_idle actual=%b required=001", {ic_resp_valid, dc_resp_valid, ic_req_ready});
        end
        step();
        ic_req_valid = 1'b0;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_A000}) begin
            failures++;
            $display("FAIL stray_issue valid=%b addr=%h required=1/0000a000", mem_req_valid, mem_req_addr);
        end
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = c_line_7;
        step();
        mem_resp_valid = 1'b0;
        checks++;
        if ({ic_resp_valid, ic_resp_data} !== {1'b1, c_line_7}) begin
            failures++;
            $display("FAIL stray_after_resp valid=%b data=%h required=1/%h", ic_resp_valid, ic_resp_data, c_line_7);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int ic_cnt;
        int dc_cnt;
        ic_cnt = 0;
        dc_cnt = 0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_8000;
        step();
        ic_req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({mem_req_valid, mem_req_write, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready} !== 6'b0) begin
            failures++;
            $display("FAIL midreset_flags actual=%b required=000000",
                     {mem_req_valid, mem_req_write, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready});
        end
        checks++;
        if ({mem_req_addr, mem_req_data, ic_resp_data, dc_resp_data} !== '0) begin
            failures++;
            $display("FAIL midreset_data addr=%h data=%h ic=%h dc=%h required=0",
                     mem_req_addr, mem_req_data, ic_resp_data, dc_resp_data);
        end
        reset = 1'b0;
        step();
        dc_req_valid = 1'b1;
        dc_req_write = 1'b0;
        dc_req_addr  = 32'h0000_9000;
        #1;
        checks++;
        if (dc_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_accept actual=%b required=1", dc_req_ready);
        end
        for (int c = 5; c <= 14; c++) begin
            step();
            if (c == 5) begin
                dc_req_valid = 1'b0;
                checks++;
                if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_9000}) begin
                    failures++;
                    $display("FAIL midreset_issue valid=%b addr=%h required=1/00009000", mem_req_valid, mem_req_addr);
                end
            end
            if (c == 6) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = c_line_8;
            end
            if (c == 7) begin
                mem_resp_valid = 1'b0;
                checks++;
                if ({dc_resp_valid, dc_resp_data} !== {1'b1, c_line_8}) begin
                    failures++;
                    $display("FAIL midreset_resp valid=%b data=%h required=1/%h", dc_resp_valid, dc_resp_data, c_line_8);
                end
            end
            if (ic_resp_valid) ic_cnt++;
            if (dc_resp_valid) dc_cnt++;
        end
        checks++;
        if (ic_cnt != 0 || dc_cnt != 1) begin
            failures++;
            $display("FAIL midreset_resp_count ic=%0d dc=%0d required ic=0 dc=1", ic_cnt, dc_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_back_to_back();
        test_held_request();
        test_stray_resp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
